// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a busy flag, owns HI/LO.
// The result is computed at accept and held until the final busy cycle.
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_t;

    op_t             op;
    state_t          state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic            res_write;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   next_hi, next_lo;
    logic               next_write, is_md, is_mul;

    assign op     = op_t'(MDUOp);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_md  = is_mul || (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        prod       = '0;
        next_hi    = '0;
        next_lo    = '0;
        next_write = 1'b0;
        unique case (op)
            OP_MULT: begin
                prod       = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
                next_hi    = prod[2*WIDTH-1:WIDTH];
                next_lo    = prod[WIDTH-1:0];
                next_write = 1'b1;
            end
            OP_MULTU: begin
                prod       = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
                next_hi    = prod[2*WIDTH-1:WIDTH];
                next_lo    = prod[WIDTH-1:0];
                next_write = 1'b1;
            end
            OP_DIV: begin
                // Divide by zero leaves HI/LO untouched; MOST_NEG / -1 wraps without a trap.
                if (B != '0) begin
                    next_write = 1'b1;
                    if (A == MOST_NEG && B == '1) begin
                        next_lo = MOST_NEG;
                        next_hi = '0;
                    end else begin
                        next_lo = $signed(A) / $signed(B);
                        next_hi = $signed(A) % $signed(B);
                    end
                end
            end
            OP_DIVU: begin
                if (B != '0) begin
                    next_write = 1'b1;
                    next_lo    = A / B;
                    next_hi    = A % B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            HI        <= '0;
            LO        <= '0;
            res_hi    <= '0;
            res_lo    <= '0;
            res_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (is_md) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            count     <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                            res_hi    <= next_hi;
                            res_lo    <= next_lo;
                            res_write <= next_write;
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // start is ignored here; the hazard unit stalls on busy.
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        if (res_write) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus random ops against a
// 64-bit arithmetic reference model of HI/LO and busy length.
module tb_e_mdu;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset, start, cancel;
    logic [2:0]   MDUOp;
    logic [W-1:0] A, B;
    logic         busy;
    logic [W-1:0] HI, LO;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] m_hi, m_lo;

    e_mdu #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    // Architectural effect of one completed operation, from plain wide arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (b != 0) begin
                q = sa / sb; r = sa - q * sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                q = longint'({32'b0, a}) / longint'({32'b0, b});
                r = longint'({32'b0, a}) - q * longint'({32'b0, b});
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue op, optionally intrude during busy cycle intr_at (kind 1: mtlo start, kind 2: cancel),
    // then check busy length and final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int intr_at, input int kind);
        int cnt, exp_cnt;
        start = 1'b1; MDUOp = op; A = a; B = b;
        step();
        start = 1'b0; MDUOp = 3'd0; A = $urandom; B = $urandom;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (cnt == intr_at) begin
                if (kind == 1) begin start = 1'b1; MDUOp = 3'd6; A = $urandom; end
                else if (kind == 2) cancel = 1'b1;
            end
            step();
            start = 1'b0; cancel = 1'b0; MDUOp = 3'd0;
        end
        exp_cnt = latency(op);
        if (kind == 2 && exp_cnt > 0 && intr_at <= exp_cnt) exp_cnt = intr_at;
        else model(op, a, b);
        check({tag, " busy_len"}, 64'(cnt), 64'(exp_cnt));
        check({tag, " HI"}, 64'(HI), 64'(m_hi));
        check({tag, " LO"}, 64'(LO), 64'(m_lo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        step(); step();
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'(0));
        check("reset HI", 64'(HI), 64'(0));
        check("reset LO", 64'(LO), 64'(0));

        run_op("mthi", 3'd5, 32'h12345678, 32'h0, 0, 0);
        run_op("mtlo", 3'd6, 32'hCAFEF00D, 32'h0, 0, 0);
        run_op("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 0, 0);
        check("mult HI const", 64'(HI), 64'hFFFFFFFF);
        check("mult LO const", 64'(LO), 64'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0, 0);
        check("multu HI const", 64'(HI), 64'h00000001);
        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        check("div_neg LO const", 64'(LO), 64'hFFFFFFFD);
        check("div_neg HI const", 64'(HI), 64'hFFFFFFFF);
        run_op("divu", 3'd4, 32'd7, 32'd2, 0, 0);
        check("divu LO const", 64'(LO), 64'd3);
        check("divu HI const", 64'(HI), 64'd1);
        run_op("div_by0", 3'd3, 32'h55, 32'h0, 0, 0);
        run_op("divu_by0", 3'd4, 32'h99, 32'h0, 0, 0);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        check("div_ovf LO const", 64'(LO), 64'h80000000);
        check("div_ovf HI const", 64'(HI), 64'h0);
        run_op("mtlo_in_run", 3'd1, 32'h00012345, 32'h00006789, 2, 1);
        run_op("cancel_c3", 3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3, 2);
        run_op("cancel_div", 3'd4, 32'hFFFF0000, 32'h3, 7, 2);
        run_op("op_none", 3'd0, 32'hDEAD, 32'hBEEF, 0, 0);
        run_op("op_rsvd", 3'd7, 32'hDEAD, 32'hBEEF, 0, 0);

        // start and cancel together while idle
        start = 1'b1; cancel = 1'b1; MDUOp = 3'd1; A = 32'h3; B = 32'h5;
        step();
        start = 1'b0; cancel = 1'b0; MDUOp = 3'd0;
        check("idle_cancel busy", 64'(busy), 64'(0));
        step();
        check("idle_cancel busy2", 64'(busy), 64'(0));
        check("idle_cancel HI", 64'(HI), 64'(m_hi));
        check("idle_cancel LO", 64'(LO), 64'(m_lo));
        start = 1'b1; cancel = 1'b1; MDUOp = 3'd5; A = 32'h1111;
        step();
        start = 1'b0; cancel = 1'b0; MDUOp = 3'd0;
        check("idle_cancel mthi", 64'(HI), 64'(m_hi));

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] ra, rb;
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d_op%0d", i, op), op, ra, rb, 0, 0);
        end

        // reset mid-operation with nonzero HI/LO
        run_op("pre_reset", 3'd2, 32'hABCDEF01, 32'h12345678, 0, 0);
        start = 1'b1; MDUOp = 3'd3; A = 32'h1000; B = 32'h7;
        step();
        start = 1'b0; MDUOp = 3'd0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst HI", 64'(HI), 64'(0));
        check("midrst LO", 64'(LO), 64'(0));
        for (int i = 0; i < DC + 2; i++) step();
        check("midrst late busy", 64'(busy), 64'(0));
        check("midrst late HI", 64'(HI), 64'(0));
        check("midrst late LO", 64'(LO), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Parametrised multiply/divide unit for the E stage, sitting beside the E-stage ALU.
- Executes signed and unsigned multiply and divide over a configurable number of cycles, and owns the architectural HI/LO registers.
- Exposes a busy flag so the hazard unit can stall dependent HI/LO instructions.
- Supports a cancel input, used when the instruction in E is flushed.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MUL_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue the operation on MDUOp this cycle.
- MDUOp  input  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=reserved (treated as none).
- A  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- cancel  input  1  abort the in-flight operation (E-stage flush).
- busy  output  1  high while a mult/div is in flight.
- HI  output  WIDTH  HI register, registered.
- LO  output  WIDTH  LO register, registered.

Behaviour:
- Reset (sync, active-high), with priority over all other inputs:
  - busy=0, HI=0, LO=0, counter=0, FSM in IDLE.
  - Reset mid-operation discards the operation; no HI/LO write.
- FSM states: IDLE, RUN.
- Accept rule:
  - IDLE, start=1, cancel=0, MDUOp in {1..4}: latch A, B and the op; load counter with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises the cycle after the start edge.
- RUN:
  - counter decrements each cycle; busy=1.
  - On the edge where counter reaches 1: write HI/LO; go to IDLE; busy=0 the next cycle.
  - Net latency: busy is high for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES).
  - The new HI/LO is visible in the same cycle busy is first 0.
- start during RUN is ignored, including mthi/mtlo. The hazard unit must stall on (start & op≠0) | busy.
- mthi/mtlo:
  - IDLE, start=1, cancel=0, MDUOp=5/6: HI (resp. LO) ← A at that edge.
  - busy stays 0; the other register is unchanged.
- cancel:
  - In RUN: return to IDLE next edge; busy=0; HI/LO unchanged.
  - In IDLE: any concurrent start is suppressed.
  - cancel together with reset: reset wins.
- Arithmetic uses the operands latched at accept; input changes during RUN have no effect.
  - mult: 2·WIDTH signed product; HI=upper half, LO=lower half.
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder, sign follows dividend.
  - divu: unsigned quotient and remainder.
- Divide boundaries:
  - B=0 (div or divu): full latency still taken; HI/LO unchanged.
  - div with A=most-negative and B=−1: LO=most-negative, HI=0; no exception.
- MDUOp=0 or 7 with start=1: no effect.
- Internally a single-cycle behavioural multiply/divide, computed at accept and held in a result register until the write, is acceptable. Only the cycle-level visibility above is normative.

Test Plan:
- Reset with HI/LO previously nonzero and an op in flight -> next cycle busy=0, HI=0, LO=0; no later write occurs.
- mult A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/2 -> LO=3, HI=1.
- div with B=0 -> HI/LO unchanged.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678 while idle -> HI=0x12345678 next cycle; LO unchanged; busy stays 0.
- mtlo issued during a busy mult -> ignored; the mult result lands normally.
- Start mult; assert cancel in busy cycle 3 -> busy=0 next cycle; HI/LO keep pre-mult values.
- Start and cancel in the same idle cycle -> busy never rises.
